fruit_spawner: RTL and testbench

FRUIT_SPAWNER -- requirements
Module: fruit_spawner

---
 rtl/fruit_spawner_pkg.sv | 18 +
 rtl/fruit_spawner_if.sv | 20 ++
 rtl/fruit_spawner.sv | 180 ++++++++++++++++++
 tb/tb_fruit_spawner.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fruit_spawner_pkg.sv
// Shared types and default parameters for the fruit spawner.
package fruit_pkg;

   typedef logic [5:0] cell_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      PROBE = 2'd2,
      CHECK = 2'd3
   } state_t;

   localparam int CELLS_DEF      = 64;
   localparam int SAMPLE_GAP_DEF = 6;
   localparam int MAX_TRIES_DEF  = 8;
   localparam int RESET_POS_DEF  = 40;

endpackage

// File: rtl/fruit_spawner_if.sv
// Occupancy query channel between the fruit spawner (master) and the snake body store (slave).
interface fruit_spawner_if;

   logic              o_probe_valid;
   fruit_pkg::cell_t  o_probe_pos;
   logic              i_probe_occupied;

   modport master (
      output o_probe_valid,
      output o_probe_pos,
      input  i_probe_occupied
   );

   modport slave (
      input  o_probe_valid,
      input  o_probe_pos,
      output i_probe_occupied
   );

endinterface

// File: rtl/fruit_spawner.sv
// Picks a free board cell for the next fruit from random samples, checking occupancy with the body store.
// Define FRUIT_FALLBACK_SCAN_EN to fall back to a linear scan (and detect a full board) after MAX_TRIES misses.
//
// state | meaning
// IDLE  | fruit held, waiting for i_spawn_req
// WAIT  | counting down gap until the next random sample
// PROBE | occupancy query for cand on the probe channel
// CHECK | probe answer arrives; place fruit or retry
module fruit_spawner
   import fruit_pkg::*;
#(
   parameter int CELLS      = CELLS_DEF,
   parameter int SAMPLE_GAP = SAMPLE_GAP_DEF,
   parameter int MAX_TRIES  = MAX_TRIES_DEF,
   parameter int RESET_POS  = RESET_POS_DEF
) (
   input  logic            i_clock,
   input  logic            i_reset,
   input  logic            i_spawn_req,
   input  cell_t           i_random,
   fruit_spawner_if.master probe,
   output cell_t           o_fruit_pos,
   output logic            o_fruit_valid,
   output logic            o_busy,
   output logic            o_spawn_done,
   output logic            o_board_full
);

   localparam int GAP_W = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
   localparam int TRY_W = $clog2(MAX_TRIES + 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(SAMPLE_GAP - 1);
   localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRIES);

   state_t            state, state_d;
   cell_t             cand, cand_d;
   logic [GAP_W-1:0]  gap, gap_d;
   logic [TRY_W-1:0]  tries, tries_d, tries_inc;
   cell_t             fruit_pos_d;
   logic              fruit_valid_d;
   logic              spawn_done_d;

`ifdef FRUIT_FALLBACK_SCAN_EN
   localparam int SCAN_W = $clog2(CELLS + 1);
   localparam logic [SCAN_W-1:0] SCAN_FULL = SCAN_W'(CELLS);
   localparam logic [TRY_W-1:0]  TRY_LAST  = TRY_W'(MAX_TRIES - 1);

   logic              scan_mode, scan_mode_d;
   logic [SCAN_W-1:0] scanned, scanned_d;
   logic              board_full_q, board_full_d;

   function automatic cell_t next_cell(input cell_t c);
      if (int'(c) >= CELLS - 1) return '0;
      return cell_t'(c + 6'd1);
   endfunction

   assign o_board_full = board_full_q;
`else
   assign o_board_full = 1'b0;
`endif

   assign o_busy    = (state != IDLE);
   assign tries_inc = (tries == TRY_MAX) ? tries : tries + 1'b1;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state         <= IDLE;
         cand          <= '0;
         gap           <= '0;
         tries         <= '0;
         o_fruit_pos   <= cell_t'(RESET_POS);
         o_fruit_valid <= 1'b1;
         o_spawn_done  <= 1'b0;
`ifdef FRUIT_FALLBACK_SCAN_EN
         scan_mode     <= 1'b0;
         scanned       <= '0;
         board_full_q  <= 1'b0;
`endif
      end else begin
         state         <= state_d;
         cand          <= cand_d;
         gap           <= gap_d;
         tries         <= tries_d;
         o_fruit_pos   <= fruit_pos_d;
         o_fruit_valid <= fruit_valid_d;
         o_spawn_done  <= spawn_done_d;
`ifdef FRUIT_FALLBACK_SCAN_EN
         scan_mode     <= scan_mode_d;
         scanned       <= scanned_d;
         board_full_q  <= board_full_d;
`endif
      end
   end

   always_comb begin
      state_d             = state;
      cand_d              = cand;
      gap_d               = gap;
      tries_d             = tries;
      fruit_pos_d         = o_fruit_pos;
      fruit_valid_d       = o_fruit_valid;
      spawn_done_d        = 1'b0;
      probe.o_probe_valid = 1'b0;
      probe.o_probe_pos   = '0;
`ifdef FRUIT_FALLBACK_SCAN_EN
      scan_mode_d         = scan_mode;
      scanned_d           = scanned;
      board_full_d        = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (i_spawn_req) begin
               fruit_valid_d = 1'b0;
               tries_d       = '0;
               gap_d         = GAP_LOAD;
               state_d       = WAIT;
`ifdef FRUIT_FALLBACK_SCAN_EN
               scan_mode_d   = 1'b0;
               scanned_d     = '0;
`endif
            end
         end
         WAIT: begin
            if (gap != '0) begin
               gap_d = gap - 1'b1;
            end else begin
               cand_d = i_random;
               // Out-of-board samples burn a try without touching the probe channel.
               if (int'(i_random) < CELLS) begin
                  state_d = PROBE;
               end else begin
                  tries_d = tries_inc;
                  gap_d   = GAP_LOAD;
               end
            end
         end
         PROBE: begin
            probe.o_probe_valid = 1'b1;
            probe.o_probe_pos   = cand;
            state_d             = CHECK;
         end
         CHECK: begin
            if (!probe.i_probe_occupied) begin
               fruit_pos_d   = cand;
               fruit_valid_d = 1'b1;
               spawn_done_d  = 1'b1;
               state_d       = IDLE;
            end else begin
`ifdef FRUIT_FALLBACK_SCAN_EN
               if (scan_mode) begin
                  if (scanned == SCAN_FULL) begin
                     board_full_d = 1'b1;
                     state_d      = IDLE;
                  end else begin
                     cand_d    = next_cell(cand);
                     scanned_d = scanned + 1'b1;
                     state_d   = PROBE;
                  end
               end else if (tries >= TRY_LAST) begin
                  scan_mode_d = 1'b1;
                  scanned_d   = SCAN_W'(1);
                  cand_d      = next_cell(cand);
                  tries_d     = TRY_MAX;
                  state_d     = PROBE;
               end else begin
                  tries_d = tries_inc;
                  gap_d   = GAP_LOAD;
                  state_d = WAIT;
               end
`else
               tries_d = tries_inc;
               gap_d   = GAP_LOAD;
               state_d = WAIT;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fruit_spawner.sv
// Directed bench for fruit_spawner: default board plus a 40-cell instance, with a bit-map body store model.
module tb_fruit_spawner;
   import fruit_pkg::*;

   logic        i_clock = 1'b0;
   logic        i_reset = 1'b1;
   logic        req = 1'b0, req40 = 1'b0;
   cell_t       rnd = '0, rnd40 = '0;
   logic [63:0] occ_map = '0, occ40 = '0;

   cell_t fruit_pos, fruit_pos40;
   logic  fv, busy, done, full;
   logic  fv40, busy40, done40, full40;

   int n_checks = 0;
   int n_fail   = 0;

   fruit_spawner_if pif ();
   fruit_spawner_if pif40 ();

   fruit_spawner dut (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_spawn_req   (req),
      .i_random      (rnd),
      .probe         (pif),
      .o_fruit_pos   (fruit_pos),
      .o_fruit_valid (fv),
      .o_busy        (busy),
      .o_spawn_done  (done),
      .o_board_full  (full)
   );

   fruit_spawner #(.CELLS(40)) dut40 (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_spawn_req   (req40),
      .i_random      (rnd40),
      .probe         (pif40),
      .o_fruit_pos   (fruit_pos40),
      .o_fruit_valid (fv40),
      .o_busy        (busy40),
      .o_spawn_done  (done40),
      .o_board_full  (full40)
   );

   always #5 i_clock = ~i_clock;

   // Body store model: answer is registered, so it is valid in the cycle after the probe.
   always @(posedge i_clock) begin
      pif.i_probe_occupied   <= pif.o_probe_valid && occ_map[pif.o_probe_pos];
      pif40.i_probe_occupied <= pif40.o_probe_valid && occ40[pif40.o_probe_pos];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge i_clock);
      #1;
   endtask

   // Request accepted on the next edge; returns just after that edge.
   task automatic pulse_req();
      req = 1'b1;
      step(1);
      req = 1'b0;
   endtask

   initial begin
      pif.i_probe_occupied   = 1'b0;
      pif40.i_probe_occupied = 1'b0;

      // Reset values while reset is held
      #12;
      chk("rst_fruit_pos",   32'(fruit_pos), 40);
      chk("rst_fruit_valid", 32'(fv), 1);
      chk("rst_busy",        32'(busy), 0);
      chk("rst_probe_valid", 32'(pif.o_probe_valid), 0);
      chk("rst_probe_pos",   32'(pif.o_probe_pos), 0);
      chk("rst_spawn_done",  32'(done), 0);
      chk("rst_board_full",  32'(full), 0);

      @(posedge i_clock);
      #1 i_reset = 1'b0;
      step(1);
      chk("post_rst_pos",   32'(fruit_pos), 40);
      chk("post_rst_valid", 32'(fv), 1);
      chk("post_rst_busy",  32'(busy), 0);

      // Best case: sample 17, free
      rnd = 6'd17;
      pulse_req();
      chk("bc_valid_cleared", 32'(fv), 0);
      chk("bc_busy",          32'(busy), 1);
      step(5);
      chk("bc_no_early_probe", 32'(pif.o_probe_valid), 0);
      step(1);
      chk("bc_probe_valid", 32'(pif.o_probe_valid), 1);
      chk("bc_probe_pos",   32'(pif.o_probe_pos), 17);
      step(1);
      chk("bc_probe_one_cycle", 32'(pif.o_probe_valid), 0);
      chk("bc_no_early_done",   32'(done), 0);
      step(1);
      chk("bc_fruit_pos",   32'(fruit_pos), 17);
      chk("bc_fruit_valid", 32'(fv), 1);
      chk("bc_spawn_done",  32'(done), 1);
      chk("bc_idle",        32'(busy), 0);
      step(1);
      chk("bc_done_pulse", 32'(done), 0);

      // First sample occupied, second free; a request during WAIT is ignored
      occ_map[17] = 1'b1;
      rnd = 6'd17;
      pulse_req();
      step(6);
      chk("retry_probe1_pos", 32'(pif.o_probe_pos), 17);
      rnd = 6'd23;
      step(2);
      chk("retry_busy",     32'(busy), 1);
      chk("retry_no_fruit", 32'(fv), 0);
      req = 1'b1;
      step(1);
      req = 1'b0;
      step(4);
      chk("retry_no_probe_early", 32'(pif.o_probe_valid), 0);
      step(1);
      chk("retry_probe2_valid", 32'(pif.o_probe_valid), 1);
      chk("retry_probe2_pos",   32'(pif.o_probe_pos), 23);
      step(2);
      chk("retry_fruit_pos", 32'(fruit_pos), 23);
      chk("retry_done",      32'(done), 1);
      chk("retry_tries",     32'(dut.tries), 1);
      occ_map[17] = 1'b0;

      // 40-cell board: sample 50 is rejected without a probe, then 12
      rnd40 = 6'd50;
      req40 = 1'b1;
      step(1);
      req40 = 1'b0;
      step(6);
      chk("c40_no_probe_50", 32'(pif40.o_probe_valid), 0);
      chk("c40_busy",        32'(busy40), 1);
      rnd40 = 6'd12;
      step(6);
      chk("c40_probe_valid", 32'(pif40.o_probe_valid), 1);
      chk("c40_probe_pos",   32'(pif40.o_probe_pos), 12);
      step(2);
      chk("c40_fruit_pos", 32'(fruit_pos40), 12);
      chk("c40_done",      32'(done40), 1);
      chk("c40_tries",     32'(dut40.tries), 1);

      // Reset during PROBE aborts the search
      rnd = 6'd9;
      pulse_req();
      step(6);
      chk("abort_in_probe", 32'(pif.o_probe_valid), 1);
      #2 i_reset = 1'b1;
      #1;
      chk("abort_probe_drop", 32'(pif.o_probe_valid), 0);
      chk("abort_fruit_pos",  32'(fruit_pos), 40);
      chk("abort_fruit_valid", 32'(fv), 1);
      chk("abort_busy",       32'(busy), 0);
      @(posedge i_clock);
      #1 i_reset = 1'b0;
      step(3);
      chk("abort_no_fruit_pos", 32'(fruit_pos), 40);
      chk("abort_still_idle",   32'(busy), 0);

      // Second pulse while busy has no effect on timing
      pulse_req();
      step(3);
      req = 1'b1;
      step(1);
      req = 1'b0;
      step(3);
      chk("busy_pulse_not_yet", 32'(fv), 0);
      step(1);
      chk("busy_pulse_fruit_pos", 32'(fruit_pos), 9);
      chk("busy_pulse_done",      32'(done), 1);
      step(2);
      chk("busy_pulse_idle", 32'(busy), 0);

`ifdef FRUIT_FALLBACK_SCAN_EN
      // All occupied except 5: eight random misses on 17, then scan 18..63,0..5
      occ_map = ~(64'd1 << 5);
      rnd = 6'd17;
      pulse_req();
      step(62);
      chk("scan_last_random_pos", 32'(pif.o_probe_pos), 17);
      step(2);
      chk("scan_first_valid", 32'(pif.o_probe_valid), 1);
      chk("scan_first_pos",   32'(pif.o_probe_pos), 18);
      step(103);
      chk("scan_not_yet", 32'(fv), 0);
      step(1);
      chk("scan_fruit_pos",   32'(fruit_pos), 5);
      chk("scan_fruit_valid", 32'(fv), 1);
      chk("scan_done",        32'(done), 1);

      // Fully occupied board
      occ_map = '1;
      pulse_req();
      step(191);
      chk("full_busy",    32'(busy), 1);
      chk("full_not_yet", 32'(full), 0);
      step(1);
      chk("full_pulse", 32'(full), 1);
      chk("full_valid", 32'(fv), 0);
      chk("full_idle",  32'(busy), 0);
      chk("full_no_done", 32'(done), 0);
      step(1);
      chk("full_pulse_end", 32'(full), 0);
`else
      // Without the scan fallback, retries continue and tries saturates
      occ_map = '1;
      pulse_req();
      step(100);
      chk("noscan_busy",       32'(busy), 1);
      chk("noscan_full_tied",  32'(full), 0);
      chk("noscan_no_fruit",   32'(fv), 0);
      chk("noscan_tries_sat",  32'(dut.tries), 8);
      i_reset = 1'b1;
      #1;
      chk("noscan_reset_idle", 32'(busy), 0);
      @(posedge i_clock);
      #1 i_reset = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
